// File: rtl/secded_shift_reg.sv
// secded_shift_reg
//   Multi-mode shift/load register (SISO-R, SISO-L, PISO, PIPO). Every stored
//   data bit is covered by a Hamming SEC-DED code plus an overall parity bit.
//   Single errors are corrected on every write. An idle cycle that holds a
//   single error writes the corrected word back (scrub). An uncorrectable word
//   is flagged and counted, and the next enabled write replaces it with a
//   freshly encoded word.
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   enable, mode      run the selected operation: 00 SISO-R, 01 SISO-L,
//                     10 PISO, 11 PIPO
//   load              modes 10/11: take parallel_in instead of shift/hold
//   serial_in         serial data for modes 00/01
//   parallel_in       parallel load data
//   inj_en, inj_mask  XOR inj_mask into the codeword written this edge
//   clr_err           clear ded_flag and both counters
//   serial_out        corrected bit 0 (modes 00/10) or bit WIDTH-1 (01/11)
//   parallel_out      corrected data of the stored word
//   sec_pulse         single error corrected (written back) this cycle
//   ded_err           stored word is uncorrectable
//   ded_flag          sticky uncorrectable-error indicator
//   sec_count         saturating count of corrections
//   ded_count         saturating count of uncorrectable-error episodes
module secded_shift_reg #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8,
  // Smallest P with 2**P >= WIDTH+P+1, valid for WIDTH >= 4
  localparam int P  = $clog2(WIDTH + $clog2(WIDTH) + 1),
  localparam int N  = WIDTH + P,
  localparam int CW = N + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic             serial_in,
  input  logic [WIDTH-1:0] parallel_in,
  input  logic             inj_en,
  input  logic [CW-1:0]    inj_mask,
  input  logic             clr_err,
  output logic             serial_out,
  output logic [WIDTH-1:0] parallel_out,
  output logic             sec_pulse,
  output logic             ded_err,
  output logic             ded_flag,
  output logic [CNT_W-1:0] sec_count,
  output logic [CNT_W-1:0] ded_count
);

  typedef enum logic {ST_OK = 1'b0, ST_DED = 1'b1} state_t;

  // Codeword bit i holds Hamming position i+1; bit CW-1 is the overall parity.
  function automatic logic [CW-1:0] encode(input logic [WIDTH-1:0] data);
    logic [CW-1:0] cw;
    logic          par;
    int            d;
    cw = '0;
    d  = 0;
    for (int pos = 1; pos <= N; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        cw[pos-1] = data[d];
        d = d + 1;
      end
    end
    // Check positions are still zero here, so including them is harmless
    for (int k = 0; k < P; k++) begin
      par = 1'b0;
      for (int pos = 1; pos <= N; pos++) begin
        if (((pos >> k) & 1) != 0) begin
          par = par ^ cw[pos-1];
        end
      end
      cw[(1 << k) - 1] = par;
    end
    cw[CW-1] = ^cw[N-1:0];
    return cw;
  endfunction

  function automatic logic [P-1:0] syndrome(input logic [CW-1:0] cw);
    logic [P-1:0] s;
    s = '0;
    for (int pos = 1; pos <= N; pos++) begin
      if (cw[pos-1]) begin
        s = s ^ P'(pos);
      end
    end
    return s;
  endfunction

  function automatic logic [WIDTH-1:0] extract(input logic [CW-1:0] cw);
    logic [WIDTH-1:0] data;
    int               d;
    data = '0;
    d    = 0;
    for (int pos = 1; pos <= N; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        data[d] = cw[pos-1];
        d = d + 1;
      end
    end
    return data;
  endfunction

  logic [CW-1:0]    cw_q, cw_d, wr_cw_s, corr_cw_s;
  logic [P-1:0]     syn_s;
  logic             op_s, single_s, ded_s;
  logic [WIDTH-1:0] data_s, next_data_s;
  state_t           state_q, state_d;
  logic             ded_flag_q, ded_flag_d;
  logic [CNT_W-1:0] sec_count_q, sec_count_d, ded_count_q, ded_count_d;

  // Decode the stored word and correct a single error at position s.
  // An uncorrectable word passes through raw (no flip).
  always_comb begin
    syn_s    = syndrome(cw_q);
    op_s     = ^cw_q;
    single_s = 1'b0;
    ded_s    = 1'b0;
    if (op_s) begin
      if (int'(syn_s) <= N) begin
        single_s = 1'b1;
      end else begin
        ded_s = 1'b1;
      end
    end else begin
      ded_s = (syn_s != '0);
    end
    corr_cw_s = cw_q;
    for (int pos = 1; pos <= N; pos++) begin
      corr_cw_s[pos-1] = cw_q[pos-1] ^ (single_s && (int'(syn_s) == pos));
    end
    data_s = extract(corr_cw_s);
  end

  // Next data for an enabled operation, always built from corrected data
  always_comb begin
    next_data_s = data_s;
    case (mode)
      2'b00:   next_data_s = {serial_in, data_s[WIDTH-1:1]};
      2'b01:   next_data_s = {data_s[WIDTH-2:0], serial_in};
      2'b10:   next_data_s = load ? parallel_in : {1'b0, data_s[WIDTH-1:1]};
      2'b11:   next_data_s = load ? parallel_in : data_s;
      default: next_data_s = data_s;
    endcase
  end

  // Codeword write: operation, scrub of a single error, or hold; injection on top
  always_comb begin
    if (enable) begin
      wr_cw_s = encode(next_data_s);
    end else if (single_s) begin
      wr_cw_s = encode(data_s);
    end else begin
      wr_cw_s = cw_q;
    end
    if (inj_en) begin
      cw_d = wr_cw_s ^ inj_mask;
    end else begin
      cw_d = wr_cw_s;
    end
  end

  // OK/DED tracking and error counters; clr_err overrides any increment
  always_comb begin
    state_d     = state_q;
    ded_flag_d  = ded_flag_q;
    sec_count_d = sec_count_q;
    ded_count_d = ded_count_q;
    case (state_q)
      ST_OK:   state_d = ded_s ? ST_DED : ST_OK;
      ST_DED:  state_d = ded_s ? ST_DED : ST_OK;
      default: state_d = ST_OK;
    endcase
    if (clr_err) begin
      ded_flag_d  = 1'b0;
      sec_count_d = '0;
      ded_count_d = '0;
    end else begin
      if (single_s && (sec_count_q != '1)) begin
        sec_count_d = sec_count_q + CNT_W'(1);
      end else begin
        sec_count_d = sec_count_q;
      end
      if ((state_q == ST_OK) && ded_s) begin
        ded_flag_d = 1'b1;
        if (ded_count_q != '1) begin
          ded_count_d = ded_count_q + CNT_W'(1);
        end else begin
          ded_count_d = ded_count_q;
        end
      end else begin
        ded_flag_d = ded_flag_q;
      end
    end
  end

  // State registers; all-zero codeword is a valid encoding of zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cw_q        <= '0;
      state_q     <= ST_OK;
      ded_flag_q  <= 1'b0;
      sec_count_q <= '0;
      ded_count_q <= '0;
    end else begin
      cw_q        <= cw_d;
      state_q     <= state_d;
      ded_flag_q  <= ded_flag_d;
      sec_count_q <= sec_count_d;
      ded_count_q <= ded_count_d;
    end
  end

  assign parallel_out = data_s;
  assign serial_out   = mode[0] ? data_s[WIDTH-1] : data_s[0];
  assign sec_pulse    = single_s;
  assign ded_err      = ded_s;
  assign ded_flag     = ded_flag_q;
  assign sec_count    = sec_count_q;
  assign ded_count    = ded_count_q;

endmodule

// File: tb/tb_secded_shift_reg.sv
// Testbench for secded_shift_reg (WIDTH=32, CNT_W=8, CW=39).
// The reference model tracks the logical data value plus the set of codeword
// bits currently flipped relative to a clean encoding: zero flips is clean,
// one flip is a correctable error, two flips are uncorrectable.
module tb_secded_shift_reg;
  localparam int W  = 32;
  localparam int CW = 39;

  logic          clk = 1'b0;
  logic          rst, enable, load, serial_in, inj_en, clr_err;
  logic [1:0]    mode;
  logic [W-1:0]  parallel_in;
  logic [CW-1:0] inj_mask;
  logic          serial_out, sec_pulse, ded_err, ded_flag;
  logic [W-1:0]  parallel_out;
  logic [7:0]    sec_count, ded_count;

  int total = 0;
  int bad   = 0;

  logic [W-1:0]  m_data;
  logic [CW-1:0] m_flip;
  logic          m_dst, m_flag;
  int            m_sec, m_dcnt;

  secded_shift_reg #(.WIDTH(W), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode), .load(load),
    .serial_in(serial_in), .parallel_in(parallel_in), .inj_en(inj_en),
    .inj_mask(inj_mask), .clr_err(clr_err), .serial_out(serial_out),
    .parallel_out(parallel_out), .sec_pulse(sec_pulse), .ded_err(ded_err),
    .ded_flag(ded_flag), .sec_count(sec_count), .ded_count(ded_count)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_pow2(input int p);
    return (p & (p - 1)) == 0;
  endfunction

  // Data seen when the flipped bits are not corrected: Hamming position p
  // that is not a power of two carries data index p - (#powers of 2 <= p) - 1.
  function automatic logic [W-1:0] raw_data(input logic [W-1:0] d, input logic [CW-1:0] f);
    logic [W-1:0] r;
    int np;
    r = d;
    for (int i = 0; i < CW - 1; i++) begin
      if (f[i] && !is_pow2(i + 1)) begin
        np = 0;
        for (int k = 0; (1 << k) <= (i + 1); k++) np++;
        r[i + 1 - np - 1] = ~r[i + 1 - np - 1];
      end
    end
    return r;
  endfunction

  task automatic reset_model();
    m_data = '0; m_flip = '0; m_dst = 1'b0; m_flag = 1'b0; m_sec = 0; m_dcnt = 0;
  endtask

  // One clock cycle: apply inputs, check outputs against model, advance model
  task automatic step(input logic en, input logic [1:0] md, input logic ld,
                      input logic si, input logic [W-1:0] pi, input logic ij,
                      input logic [CW-1:0] mk, input logic cl);
    logic [W-1:0] cur;
    logic single, ded;
    int nf;
    enable = en; mode = md; load = ld; serial_in = si; parallel_in = pi;
    inj_en = ij; inj_mask = mk; clr_err = cl;
    #1;
    nf = $countones(m_flip);
    single = (nf == 1);
    ded = (nf == 2);
    cur = ded ? raw_data(m_data, m_flip) : m_data;
    chk("parallel_out", parallel_out, cur);
    chk("serial_out", 32'(serial_out), 32'((md == 2'd0 || md == 2'd2) ? cur[0] : cur[W-1]));
    chk("sec_pulse", 32'(sec_pulse), 32'(single));
    chk("ded_err", 32'(ded_err), 32'(ded));
    chk("ded_flag", 32'(ded_flag), 32'(m_flag));
    chk("sec_count", 32'(sec_count), 32'(m_sec));
    chk("ded_count", 32'(ded_count), 32'(m_dcnt));
    if (en) begin
      case (md)
        2'd0:    m_data = {si, cur[W-1:1]};
        2'd1:    m_data = {cur[W-2:0], si};
        2'd2:    m_data = ld ? pi : {1'b0, cur[W-1:1]};
        default: m_data = ld ? pi : cur;
      endcase
      m_flip = '0;
    end else if (single) begin
      m_flip = '0;
    end
    if (ij) m_flip = m_flip ^ mk;
    if (cl) begin
      m_sec = 0; m_dcnt = 0; m_flag = 1'b0;
    end else begin
      if (single && m_sec < 255) m_sec++;
      if (!m_dst && ded) begin
        m_flag = 1'b1;
        if (m_dcnt < 255) m_dcnt++;
      end
    end
    m_dst = ded;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic hold();
    step(1'b0, 2'd3, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic inject(input logic [CW-1:0] mk);
    step(1'b0, 2'd3, 1'b0, 1'b0, '0, 1'b1, mk, 1'b0);
  endtask

  // Reset asserted between clock edges must act immediately
  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    chk("async_rst_par", parallel_out, 32'h0);
    chk("async_rst_serial", 32'(serial_out), 32'h0);
    chk("async_rst_sec_count", 32'(sec_count), 32'h0);
    chk("async_rst_ded_flag", 32'(ded_flag), 32'h0);
    reset_model();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [CW-1:0] mk;
    int b1, b2, nf;
    logic en, ij;
    rst = 1'b1; enable = 1'b0; mode = 2'd0; load = 1'b0; serial_in = 1'b0;
    parallel_in = '0; inj_en = 1'b0; inj_mask = '0; clr_err = 1'b0;
    reset_model();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    hold();

    // PIPO load
    step(1'b1, 2'd3, 1'b1, 1'b0, 32'hDEADBEEF, 1'b0, '0, 1'b0);
    chk("load_par", parallel_out, 32'hDEADBEEF);
    chk("load_clean", 32'({sec_pulse, ded_err}), 32'h0);

    // Single error on data[0] (mask bit 2), scrubbed on the next edge
    mk = '0; mk[2] = 1'b1;
    inject(mk);
    chk("inj_sec_pulse", 32'(sec_pulse), 32'h1);
    chk("inj_par", parallel_out, 32'hDEADBEEF);
    hold();
    chk("scrub_sec_count", 32'(sec_count), 32'h1);
    chk("scrub_clean", 32'(sec_pulse), 32'h0);

    // Double error at positions 2 and 3: raw data shows data[0] flipped
    inject(39'h6);
    chk("ded_err", 32'(ded_err), 32'h1);
    chk("ded_raw_par", parallel_out, 32'hDEADBEEE);
    repeat (5) hold();
    chk("ded_count_once", 32'(ded_count), 32'h1);
    chk("ded_flag_set", 32'(ded_flag), 32'h1);
    step(1'b1, 2'd3, 1'b1, 1'b0, 32'h12345678, 1'b0, '0, 1'b0);
    chk("ded_cleared", 32'(ded_err), 32'h0);
    chk("ded_flag_sticky", 32'(ded_flag), 32'h1);
    chk("ded_load_par", parallel_out, 32'h12345678);
    step(1'b0, 2'd3, 1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
    chk("clr_ded_flag", 32'(ded_flag), 32'h0);

    // Overall parity bit only
    mk = '0; mk[CW-1] = 1'b1;
    inject(mk);
    chk("par_sec_pulse", 32'(sec_pulse), 32'h1);
    chk("par_data", parallel_out, 32'h12345678);
    hold();

    // SISO-R of ones from reset with one injection at cycle 10, then async reset mid-shift
    async_reset();
    for (int i = 0; i < 32; i++) begin
      mk = '0;
      mk[$urandom_range(CW - 1, 0)] = 1'b1;
      step(1'b1, 2'd0, 1'b0, 1'b1, '0, (i == 10), mk, 1'b0);
    end
    chk("siso_par", parallel_out, 32'hFFFFFFFF);
    chk("siso_sec_count", 32'(sec_count), 32'h1);
    for (int i = 0; i < 5; i++) step(1'b1, 2'd1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    async_reset();

    // Counter saturation, then clear in the same cycle as a correction
    for (int i = 0; i < 300; i++) begin
      mk = '0;
      mk[$urandom_range(CW - 1, 0)] = 1'b1;
      inject(mk);
    end
    chk("sec_saturate", 32'(sec_count), 32'd255);
    step(1'b0, 2'd2, 1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
    chk("clr_wins", 32'(sec_count), 32'h0);

    // Random operations with occasional single/double injections
    for (int i = 0; i < 600; i++) begin
      en = ($urandom_range(1, 0) == 1);
      nf = $countones(m_flip);
      ij = 1'b0;
      mk = '0;
      if ((en || nf == 1 || nf == 0) && ($urandom_range(3, 0) == 0)) begin
        ij = 1'b1;
        b1 = $urandom_range(CW - 1, 0);
        mk[b1] = 1'b1;
        if ($urandom_range(1, 0) == 1) begin
          b2 = b1;
          while (b2 == b1) b2 = $urandom_range(CW - 1, 0);
          mk[b2] = 1'b1;
        end
      end
      step(en, 2'($urandom_range(3, 0)), ($urandom_range(1, 0) == 1),
           ($urandom_range(1, 0) == 1), $urandom, ij, mk, ($urandom_range(31, 0) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
